// File: rtl/aes_ahb_dma_if.sv
// AHB-Lite bus bundle between the AES block sequencer and the data memory
// slave.
//
// Signals:
//   HADDR, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HWDATA
//     Driven by the master.
//   HRDATA, HREADY, HRESP
//     Driven by the slave.
//
// Modports:
//   master - the sequencer's view of the bus.
//   slave  - the memory's view of the bus.
interface aes_ahb_dma_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] HADDR;
  logic                  HWRITE;
  logic [2:0]            HSIZE;
  logic [2:0]            HBURST;
  logic [3:0]            HPROT;
  logic [1:0]            HTRANS;
  logic                  HMASTLOCK;
  logic [DATA_WIDTH-1:0] HWDATA;
  logic [DATA_WIDTH-1:0] HRDATA;
  logic                  HREADY;
  logic                  HRESP;

  modport master (
    output HADDR, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HWDATA,
    input  HRDATA, HREADY, HRESP
  );

  modport slave (
    input  HADDR, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HWDATA,
    output HRDATA, HREADY, HRESP
  );
endinterface

// File: rtl/aes_ahb_dma.sv
// AHB-Lite single-master sequencer that streams 128-bit blocks between data
// memory and an AES-128 core. For each block it does the following:
//   - reads four words from the source buffer,
//   - pulses the core's start,
//   - waits for the core's done,
//   - writes the four result words to the destination buffer.
// This repeats for the programmed number of blocks.
//
// Ports:
//   HCLK, HRESETn   - clock, asynchronous active-low reset
//   cfg_start       - launch pulse, only honoured while idle
//   cfg_src_addr    - source byte address, latched on start
//   cfg_dst_addr    - destination byte address, latched on start
//   cfg_nblocks     - block count, latched on start
//   busy            - job in progress
//   done            - one-cycle end-of-job pulse
//   error           - sticky bus error flag
//   ahb             - AHB-Lite master (non-pipelined single word transfers)
//   aes_start       - one-cycle start pulse to the AES core
//   aes_din         - input block to the AES core
//   aes_dout        - result block from the AES core
//   aes_done        - one-cycle result-valid pulse from the AES core
module aes_ahb_dma #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  cfg_start,
  input  logic [ADDR_WIDTH-1:0] cfg_src_addr,
  input  logic [ADDR_WIDTH-1:0] cfg_dst_addr,
  input  logic [CNT_WIDTH-1:0]  cfg_nblocks,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  aes_ahb_dma_if.master         ahb,
  output logic                  aes_start,
  output logic [127:0]          aes_din,
  input  logic [127:0]          aes_dout,
  input  logic                  aes_done
);

  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(3);
  localparam logic [ADDR_WIDTH-1:0] WORD_BYTES = ADDR_WIDTH'(4);

  typedef enum logic [3:0] {
    S_IDLE, S_RD_A, S_RD_D, S_AES_GO, S_AES_W, S_WR_A, S_WR_D, S_FIN, S_ERR
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] src_q, src_d;
  logic [ADDR_WIDTH-1:0] dst_q, dst_d;
  logic [CNT_WIDTH-1:0]  blk_q, blk_d;
  logic [1:0]            w_q, w_d;
  logic [127:0]          din_q, din_d;
  logic [127:0]          res_q, res_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  // Word 0 is the most significant word of the block.
  function automatic logic [127:0] put_word(input logic [127:0]          blk,
                                            input logic [1:0]            idx,
                                            input logic [DATA_WIDTH-1:0] word);
    logic [127:0] r;
    r = blk;
    case (idx)
      2'd0:    r[127:96] = word;
      2'd1:    r[95:64]  = word;
      2'd2:    r[63:32]  = word;
      default: r[31:0]   = word;
    endcase
    return r;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] get_word(input logic [127:0] blk,
                                                     input logic [1:0]   idx);
    case (idx)
      2'd0:    return blk[127:96];
      2'd1:    return blk[95:64];
      2'd2:    return blk[63:32];
      default: return blk[31:0];
    endcase
  endfunction

  // State and datapath registers.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      blk_q   <= '0;
      w_q     <= '0;
      din_q   <= '0;
      res_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      blk_q   <= blk_d;
      w_q     <= w_d;
      din_q   <= din_d;
      res_q   <= res_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    blk_d   = blk_q;
    w_d     = w_q;
    din_d   = din_q;
    res_d   = res_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;

    unique case (state_q)
      S_IDLE: begin
        if (cfg_start) begin
          src_d   = cfg_src_addr & ALIGN_MASK;
          dst_d   = cfg_dst_addr & ALIGN_MASK;
          blk_d   = cfg_nblocks;
          w_d     = 2'd0;
          err_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = (cfg_nblocks == '0) ? S_FIN : S_RD_A;
        end
      end

      // The address phase always completes: sole master, HREADY high when idle.
      S_RD_A: state_d = S_RD_D;

      S_RD_D: begin
        // HRESP is checked first so that either cycle of an error response aborts.
        if (ahb.HRESP) begin
          state_d = S_ERR;
        end else if (ahb.HREADY) begin
          din_d = put_word(din_q, w_q, ahb.HRDATA);
          src_d = src_q + WORD_BYTES;
          if (w_q != 2'd3) begin
            w_d     = w_q + 2'd1;
            state_d = S_RD_A;
          end else begin
            w_d     = 2'd0;
            state_d = S_AES_GO;
          end
        end
      end

      S_AES_GO: state_d = S_AES_W;

      S_AES_W: begin
        if (aes_done) begin
          res_d   = aes_dout;
          state_d = S_WR_A;
        end
      end

      S_WR_A: state_d = S_WR_D;

      S_WR_D: begin
        if (ahb.HRESP) begin
          state_d = S_ERR;
        end else if (ahb.HREADY) begin
          dst_d = dst_q + WORD_BYTES;
          if (w_q != 2'd3) begin
            w_d     = w_q + 2'd1;
            state_d = S_WR_A;
          end else begin
            w_d     = 2'd0;
            blk_d   = blk_q - CNT_WIDTH'(1);
            state_d = (blk_q == CNT_WIDTH'(1)) ? S_FIN : S_RD_A;
          end
        end
      end

      S_FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      S_ERR: begin
        err_d   = 1'b1;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Bus and core outputs, decoded from the current state.
  // HTRANS is IDLE in every data-phase cycle, so aborting on an error
  // leaves the bus protocol-legal.
  always_comb begin
    ahb.HTRANS    = 2'b00;
    ahb.HWRITE    = 1'b0;
    ahb.HADDR     = '0;
    ahb.HWDATA    = '0;
    ahb.HSIZE     = 3'b010;
    ahb.HBURST    = 3'b000;
    ahb.HPROT     = 4'b0011;
    ahb.HMASTLOCK = 1'b0;
    aes_start     = 1'b0;

    unique case (state_q)
      S_RD_A: begin
        ahb.HTRANS = 2'b10;
        ahb.HADDR  = src_q;
      end
      S_WR_A: begin
        ahb.HTRANS = 2'b10;
        ahb.HWRITE = 1'b1;
        ahb.HADDR  = dst_q;
      end
      // w_q and res_q are frozen while waiting, so HWDATA holds through wait states.
      S_WR_D:   ahb.HWDATA = get_word(res_q, w_q);
      S_AES_GO: aes_start  = 1'b1;
      default: ;
    endcase
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign error   = err_q;
  assign aes_din = din_q;

endmodule

// File: tb/tb_aes_ahb_dma.sv
module tb_aes_ahb_dma;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int CW = 16;

  logic           HCLK = 1'b0;
  logic           HRESETn;
  logic           cfg_start = 1'b0;
  logic [AW-1:0]  cfg_src_addr = '0;
  logic [AW-1:0]  cfg_dst_addr = '0;
  logic [CW-1:0]  cfg_nblocks = '0;
  logic           busy, done, error;
  logic           aes_start;
  logic [127:0]   aes_din;
  logic [127:0]   aes_dout;
  logic           aes_done;

  aes_ahb_dma_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ahb ();

  aes_ahb_dma #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .HCLK         (HCLK),
    .HRESETn      (HRESETn),
    .cfg_start    (cfg_start),
    .cfg_src_addr (cfg_src_addr),
    .cfg_dst_addr (cfg_dst_addr),
    .cfg_nblocks  (cfg_nblocks),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .ahb          (ahb),
    .aes_start    (aes_start),
    .aes_din      (aes_din),
    .aes_dout     (aes_dout),
    .aes_done     (aes_done)
  );

  always #5 HCLK = ~HCLK;

  int n_assert = 0;
  int n_fail   = 0;

  // ---------------- memory slave ----------------
  logic [31:0] mem [0:511];
  logic        dp, dp_wr, hready, hresp, first;
  logic [31:0] dp_addr, hold;
  logic [1:0]  errph;
  int          wleft;
  int          waits = 0;
  logic [31:0] err_addr = 32'hFFFF_FFFF;
  logic [31:0] wlog_addr [0:255];
  logic [31:0] wlog_data [0:255];
  int          nw = 0;
  int          unstable = 0;

  assign ahb.HREADY = hready;
  assign ahb.HRESP  = hresp;
  assign ahb.HRDATA = (dp && !dp_wr) ? mem[dp_addr[10:2]] : 32'h0;

  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp <= 1'b0; dp_wr <= 1'b0; dp_addr <= '0; hready <= 1'b1; hresp <= 1'b0;
      errph <= 2'd0; wleft <= 0; first <= 1'b0; hold <= '0;
    end else begin
      if (dp && dp_wr && errph == 2'd0) begin
        if (first) begin hold <= ahb.HWDATA; first <= 1'b0; end
        else if (ahb.HWDATA !== hold) unstable <= unstable + 1;
      end
      if (dp && hready) begin
        if (dp_wr && !hresp && nw < 256) begin
          wlog_addr[nw] <= dp_addr;
          wlog_data[nw] <= ahb.HWDATA;
        end
        if (dp_wr && !hresp) nw <= nw + 1;
        dp <= 1'b0; hresp <= 1'b0; errph <= 2'd0;
      end else if (dp) begin
        if (errph == 2'd1) begin hready <= 1'b1; errph <= 2'd2; end
        else begin
          if (wleft == 1) hready <= 1'b1;
          wleft <= wleft - 1;
        end
      end
      if (ahb.HTRANS == 2'b10) begin
        dp <= 1'b1; dp_wr <= ahb.HWRITE; dp_addr <= ahb.HADDR; first <= 1'b1;
        if (!ahb.HWRITE && ahb.HADDR == err_addr) begin
          hready <= 1'b0; hresp <= 1'b1; errph <= 2'd1;
        end else begin
          wleft <= waits; hready <= (waits == 0);
        end
      end
    end
  end

  // ---------------- bus / done monitor ----------------
  logic [31:0] log_addr [0:255];
  logic        log_wr   [0:255];
  int          nlog = 0;
  int          bad_htrans = 0;
  int          ndone = 0;

  always @(posedge HCLK) begin
    if (HRESETn === 1'b1) begin
      if (ahb.HTRANS == 2'b10) begin
        if (nlog < 256) begin log_addr[nlog] <= ahb.HADDR; log_wr[nlog] <= ahb.HWRITE; end
        nlog <= nlog + 1;
      end else if (ahb.HTRANS != 2'b00) bad_htrans <= bad_htrans + 1;
      if (done === 1'b1) ndone <= ndone + 1;
    end
  end

  // ---------------- AES model: dout = ~din, done 10 cycles after start ----------------
  logic [127:0] alat;
  int           acnt;
  int           nstart = 0;

  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      acnt <= 0; aes_done <= 1'b0; aes_dout <= '0; alat <= '0;
    end else begin
      aes_done <= 1'b0;
      if (aes_start) begin
        alat <= aes_din; acnt <= 9; nstart <= nstart + 1;
      end else if (acnt != 0) begin
        acnt <= acnt - 1;
        if (acnt == 1) begin aes_done <= 1'b1; aes_dout <= ~alat; end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge HCLK);
    #1;
  endtask

  // Returns one cycle after the edge that samples cfg_start.
  task automatic start_job(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n);
    @(posedge HCLK); #1;
    cfg_src_addr = s; cfg_dst_addr = d; cfg_nblocks = n; cfg_start = 1'b1;
    @(posedge HCLK); #1;
    cfg_start = 1'b0;
  endtask

  // cyc = cycle in which done is seen (1 = first cycle after the start edge).
  task automatic wait_done(input int budget, output int cyc, output int gaps);
    cyc  = 1;
    gaps = 0;
    while (done !== 1'b1 && cyc < budget) begin
      if (busy !== 1'b1) gaps++;
      @(posedge HCLK); #1;
      cyc++;
    end
  endtask

  logic [31:0] t1_exp [0:3];

  initial begin
    int cyc, gaps, bad, nlog0, nw0, ndone0, nstart0;
    logic [127:0] blk_exp;

    t1_exp[0] = 32'hFFEEDDCC; t1_exp[1] = 32'hBBAA9988;
    t1_exp[2] = 32'h77665544; t1_exp[3] = 32'h33221100;
    for (int i = 0; i < 512; i++) mem[i] = 32'hC0DE_0000 + i;
    mem[64] = 32'h00112233; mem[65] = 32'h44556677;
    mem[66] = 32'h8899AABB; mem[67] = 32'hCCDDEEFF;

    // Reset state
    HRESETn = 1'b1;
    #1 HRESETn = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_htrans", ahb.HTRANS, 0);
    check("rst_haddr", ahb.HADDR, 0);
    check("rst_aes_din", aes_din, 0);
    check("rst_aes_start", aes_start, 0);
    repeat (3) @(posedge HCLK);
    #1 HRESETn = 1'b1;
    idle(2);

    // Test 1: single block, zero-wait memory
    nlog0 = nlog; nw0 = nw; ndone0 = ndone; nstart0 = nstart;
    start_job(32'h100, 32'h200, 16'd1);
    check("t1_busy_c1", busy, 1);
    wait_done(200, cyc, gaps);
    check("t1_done_seen", done, 1);
    check("t1_done_cycle", cyc, 29);
    check("t1_busy_gaps", gaps, 0);
    check("t1_busy_at_done", busy, 0);
    check("t1_error", error, 0);
    blk_exp = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    check("t1_aes_din", aes_din, blk_exp);
    check("t1_aes_captured", alat, blk_exp);
    idle(2);
    check("t1_ndone", ndone - ndone0, 1);
    check("t1_nstart", nstart - nstart0, 1);
    check("t1_nxfer", nlog - nlog0, 8);
    check("t1_nwrites", nw - nw0, 4);
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      if (wlog_addr[nw0 + i] !== 32'h200 + 4 * i) bad++;
      if (wlog_data[nw0 + i] !== t1_exp[i]) bad++;
    end
    check("t1_write_image", bad, 0);

    // Test 2: three blocks, strict transfer order, ignored mid-job start
    nlog0 = nlog; nw0 = nw; ndone0 = ndone; nstart0 = nstart;
    start_job(32'h000, 32'h400, 16'd3);
    idle(5);
    cfg_src_addr = 32'h700; cfg_dst_addr = 32'h700; cfg_nblocks = 16'd5; cfg_start = 1'b1;
    idle(1);
    cfg_start = 1'b0;
    wait_done(400, cyc, gaps);
    check("t2_done_seen", done, 1);
    check("t2_busy_gaps", gaps, 0);
    idle(3);
    check("t2_ndone", ndone - ndone0, 1);
    check("t2_nstart", nstart - nstart0, 3);
    check("t2_nxfer", nlog - nlog0, 24);
    bad = 0;
    for (int b = 0; b < 3; b++)
      for (int i = 0; i < 4; i++) begin
        if (log_addr[nlog0 + 8 * b + i] !== 32'h000 + 16 * b + 4 * i) bad++;
        if (log_wr[nlog0 + 8 * b + i] !== 1'b0) bad++;
        if (log_addr[nlog0 + 8 * b + 4 + i] !== 32'h400 + 16 * b + 4 * i) bad++;
        if (log_wr[nlog0 + 8 * b + 4 + i] !== 1'b1) bad++;
      end
    check("t2_xfer_order", bad, 0);
    bad = 0;
    for (int k = 0; k < 12; k++)
      if (wlog_data[nw0 + k] !== ~mem[k]) bad++;
    check("t2_write_image", bad, 0);

    // Test 3: three wait states per data phase
    waits = 3;
    nlog0 = nlog; nw0 = nw; ndone0 = ndone; nstart0 = nstart;
    start_job(32'h000, 32'h600, 16'd2);
    wait_done(400, cyc, gaps);
    check("t3_done_seen", done, 1);
    check("t3_done_cycle", cyc, 104);
    idle(3);
    check("t3_nxfer", nlog - nlog0, 16);
    check("t3_nwrites", nw - nw0, 8);
    check("t3_hwdata_stable", unstable, 0);
    check("t3_nstart", nstart - nstart0, 2);
    bad = 0;
    for (int k = 0; k < 8; k++) begin
      if (wlog_addr[nw0 + k] !== 32'h600 + 4 * k) bad++;
      if (wlog_data[nw0 + k] !== ~mem[k]) bad++;
    end
    check("t3_write_image", bad, 0);
    waits = 0;

    // Test 4: error response on the 2nd read of block 0
    err_addr = 32'h104;
    nlog0 = nlog; ndone0 = ndone; nstart0 = nstart;
    start_job(32'h100, 32'h300, 16'd2);
    wait_done(100, cyc, gaps);
    check("t4_done_seen", done, 1);
    check("t4_error", error, 1);
    check("t4_busy", busy, 0);
    idle(6);
    check("t4_nxfer", nlog - nlog0, 2);
    check("t4_last_addr", log_addr[nlog0 + 1], 32'h104);
    check("t4_no_aes_start", nstart - nstart0, 0);
    check("t4_ndone", ndone - ndone0, 1);
    check("t4_error_sticky", error, 1);
    err_addr = 32'hFFFF_FFFF;

    // Test 5: zero blocks; also clears the sticky error
    nlog0 = nlog; ndone0 = ndone;
    start_job(32'h100, 32'h300, 16'd0);
    check("t5_error_cleared", error, 0);
    check("t5_busy_c1", busy, 1);
    wait_done(20, cyc, gaps);
    check("t5_done_seen", done, 1);
    check("t5_done_cycle", cyc, 2);
    idle(3);
    check("t5_nxfer", nlog - nlog0, 0);
    check("t5_ndone", ndone - ndone0, 1);

    // Test 6: reset while waiting on the AES core
    ndone0 = ndone;
    start_job(32'h100, 32'h300, 16'd1);
    idle(12);
    check("t6_busy_pre", busy, 1);
    check("t6_din_pre", aes_din, 128'h00112233_44556677_8899AABB_CCDDEEFF);
    #2 HRESETn = 1'b0;
    #1;
    check("t6_busy", busy, 0);
    check("t6_done", done, 0);
    check("t6_error", error, 0);
    check("t6_htrans", ahb.HTRANS, 0);
    check("t6_haddr", ahb.HADDR, 0);
    check("t6_hwrite", ahb.HWRITE, 0);
    check("t6_hwdata", ahb.HWDATA, 0);
    check("t6_aes_start", aes_start, 0);
    check("t6_aes_din", aes_din, 0);
    @(posedge HCLK); #1 HRESETn = 1'b1;
    nlog0 = nlog;
    idle(40);
    check("t6_no_done", ndone - ndone0, 0);
    check("t6_no_xfer", nlog - nlog0, 0);
    check("t6_busy_post", busy, 0);

    // Fixed bus attributes and legal HTRANS encoding throughout
    check("hsize", ahb.HSIZE, 3'b010);
    check("hburst", ahb.HBURST, 3'b000);
    check("hprot", ahb.HPROT, 4'b0011);
    check("hmastlock", ahb.HMASTLOCK, 0);
    check("htrans_legal", bad_htrans, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_ahb_dma.md
Name: aes_ahb_dma

Overview:
AHB-Lite single-master sequencer that streams 128-bit blocks between the data memory and the AES-128 core. For each block it reads four 32-bit words from a source buffer, starts the AES core, waits for the core to finish, and writes the four result words to a destination buffer. It repeats this for a programmed block count and then signals completion. It sits between the configuration interface and the AHB-Lite bus that the data memory slave is attached to.

Parameters:
ADDR_WIDTH, 32, AHB address width
DATA_WIDTH, 32, AHB data width; fixed at 32, since 4 words make up one AES block
CNT_WIDTH, 16, width of the block counter

Ports:
HCLK  in  1  clock; all logic is on the rising edge
HRESETn  in  1  asynchronous, active-low reset
cfg_start  in  1  single-cycle pulse that launches a job; sampled only in IDLE
cfg_src_addr  in  ADDR_WIDTH  source byte address, word aligned; latched on start
cfg_dst_addr  in  ADDR_WIDTH  destination byte address, word aligned; latched on start
cfg_nblocks  in  CNT_WIDTH  number of 128-bit blocks to process; latched on start
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse when a job ends (normal end or error)
error  out  1  sticky high after an HRESP error; cleared by the next accepted start
HADDR  out  ADDR_WIDTH  AHB address
HWRITE  out  1  AHB write flag
HSIZE  out  3  always 3'b010 (word)
HBURST  out  3  always 3'b000 (SINGLE)
HPROT  out  4  always 4'b0011
HTRANS  out  2  2'b00 IDLE or 2'b10 NONSEQ; no other values are driven
HMASTLOCK  out  1  always 0
HWDATA  out  DATA_WIDTH  write data, driven during the data phase
HRDATA  in  DATA_WIDTH  read data
HREADY  in  1  transfer-complete signal
HRESP  in  1  error response
aes_start  out  1  one-cycle pulse that starts the AES core
aes_din  out  128  block presented to the AES core; held stable until aes_done
aes_dout  in  128  AES result
aes_done  in  1  one-cycle pulse from the AES core when aes_dout is valid

Behaviour:
- Reset (async assert, sync release) sets the following values:
  - State IDLE.
  - HTRANS=00, HADDR=0, HWRITE=0, HWDATA=0.
  - busy=0, done=0, error=0, aes_start=0, aes_din=0.
  - Counters and address registers 0.
- Reset mid-job aborts immediately. No done pulse is produced afterwards.
- The bus uses non-pipelined single transfers: every transfer is one address-phase cycle followed by data-phase cycles. HTRANS=IDLE during every data-phase cycle.
- States and transitions:
  - IDLE: if cfg_start, latch the config, clear error, set word index w=0. If nblocks=0, go to FIN; otherwise go to RD_A.
  - RD_A: drive HTRANS=NONSEQ, HWRITE=0, HADDR=src. Go to RD_D on the next cycle; the address phase always completes because this master is the only master and HREADY is high in IDLE.
  - RD_D: wait while HREADY=0.
    - On HREADY=1 with HRESP=0: capture HRDATA into word w of aes_din (w=0 goes to [127:96], w=3 goes to [31:0]), then src+=4.
    - If w<3: w+=1 and go to RD_A. Otherwise: w=0 and go to AES_GO.
  - AES_GO: pulse aes_start for one cycle, then go to AES_W.
  - AES_W: wait for aes_done, then latch aes_dout into the result register and go to WR_A. There is no timeout.
  - WR_A: drive HTRANS=NONSEQ, HWRITE=1, HADDR=dst. Go to WR_D.
  - WR_D: drive HWDATA with result word w (same word ordering as the read). Hold HWDATA stable while HREADY=0.
    - On HREADY=1 with HRESP=0: dst+=4.
    - If w<3: w+=1 and go to WR_A.
    - Otherwise: decrement the remaining-block count. If it reaches 0, go to FIN; otherwise w=0 and go to RD_A.
  - FIN: pulse done for one cycle, drop busy, go to IDLE.
  - ERR: set error=1, then behave as FIN.
- Error handling: HRESP=1 seen in RD_D or WR_D (on either cycle of the two-cycle error response) goes to ERR. The master is already driving IDLE, so the bus stays protocol-legal. No further transfers are issued.
- Address arithmetic is modulo 2^ADDR_WIDTH; wrap-around is allowed and not flagged.
- Address alignment: the low 2 bits of the src and dst registers are forced to 0.
- cfg_start while busy is ignored, with no effect on the running job.
- aes_done outside AES_W is ignored.
- Throughput with zero-wait memory: 2 cycles per word, giving 16 bus cycles per block plus 1 cycle (AES_GO) plus the AES latency.

Test Plan:
- Zero-wait memory: src=0x100 holds 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF; nblocks=1; the AES model returns ~din after 10 cycles. Required: aes_din=0x00112233_44556677_8899AABB_CCDDEEFF. Writes to 0x200..0x20C are 0xFFEEDDCC, 0xBBAA9988, 0x77665544, 0x33221100. done pulses once; busy spans the whole job.
- nblocks=3, src=0x000, dst=0x400: exactly 12 reads at 0x000..0x02C and 12 writes at 0x400..0x42C, in order, with HTRANS=NONSEQ for exactly one cycle per transfer.
- Slave inserts 3 wait states (HREADY=0) on every data phase: HWDATA and captured data are still correct, no duplicate transfers occur, and the job completes with the same memory image.
- HRESP error on the 2nd read of block 0: no further NONSEQ transfers, error=1, done pulse, and aes_start never asserted. The next cfg_start clears error.
- nblocks=0: done pulses 2 cycles after cfg_start, with no bus activity. A cfg_start pulsed mid-job is ignored.
- HRESETn asserted during AES_W: all outputs return to reset values asynchronously, and there is no done pulse after release.
